// File: rtl/shared_mul_arbiter_pkg.sv
// shared_mul_pkg: constants and the product helper shared by the
// shared_mul_arbiter RTL and its testbench.
//   MUL_N / MUL_CLIENTS : default operand width / requester count
//   PERF_CNT_W          : width of the optional performance counters
//   MUL_MAX_N           : widest operand the product helper supports
package shared_mul_pkg;

    localparam int MUL_N       = 8;
    localparam int MUL_CLIENTS = 2;
    localparam int PERF_CNT_W  = 16;
    localparam int MUL_MAX_N   = 32;

    // Operands arrive zero-extended to MUL_MAX_N bits; only the low w bits
    // are meaningful. Both operands are extended to twice the maximum width
    // (sign or zero, per signed_mul), so the low 2*w bits of the truncated
    // unsigned product equal the exact signed or unsigned result.
    function automatic logic [2*MUL_MAX_N-1:0] signed_or_unsigned_product(
        input logic [MUL_MAX_N-1:0] a,
        input logic [MUL_MAX_N-1:0] b,
        input logic                 signed_mul,
        input int                   w
    );
        logic [2*MUL_MAX_N-1:0]       ax;
        logic [2*MUL_MAX_N-1:0]       bx;
        logic [$clog2(MUL_MAX_N)-1:0] msb;
        msb = ($clog2(MUL_MAX_N))'(w - 1);
        ax  = {{MUL_MAX_N{1'b0}}, a};
        bx  = {{MUL_MAX_N{1'b0}}, b};
        for (int i = 0; i < 2*MUL_MAX_N; i++) begin
            if (i >= w) begin
                ax[i] = signed_mul & a[msb];
                bx[i] = signed_mul & b[msb];
            end
        end
        return ax * bx;
    endfunction

endpackage

// File: rtl/shared_mul_arbiter_if.sv
// shared_mul_arbiter_if: request/response bundle of the shared multiplier.
//   req_valid/req_ready/req_signed : per-client handshake and signed flag
//   req_a/req_b                    : packed operands, client i at [i*n +: n]
//   res_valid/res_ready            : single response handshake
//   res_id/res                     : issuing client and 2n-bit product
// modport master drives requests and res_ready; modport slave is the block.
interface shared_mul_arbiter_if
    import shared_mul_pkg::*;
#(
    parameter int n         = MUL_N,
    parameter int n_clients = MUL_CLIENTS
);
    localparam int id_w = $clog2(n_clients);

    logic [n_clients-1:0]   req_valid;
    logic [n_clients-1:0]   req_ready;
    logic [n_clients*n-1:0] req_a;
    logic [n_clients*n-1:0] req_b;
    logic [n_clients-1:0]   req_signed;
    logic                   res_valid;
    logic                   res_ready;
    logic [id_w-1:0]        res_id;
    logic [2*n-1:0]         res;

    modport master (
        output req_valid, req_a, req_b, req_signed, res_ready,
        input  req_ready, res_valid, res_id, res
    );

    modport slave (
        input  req_valid, req_a, req_b, req_signed, res_ready,
        output req_ready, res_valid, res_id, res
    );

endinterface

// File: rtl/shared_mul_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req      : request vector
//   ptr      : highest-priority index this cycle
//   grant    : one-hot grant (zero when nothing requests)
//   grant_id : binary index of the granted requester
module rr_arbiter #(
    parameter  int n_clients = 2,
    localparam int id_w      = $clog2(n_clients)
) (
    input  logic [n_clients-1:0] req,
    input  logic [id_w-1:0]      ptr,
    output logic [n_clients-1:0] grant,
    output logic [id_w-1:0]      grant_id
);

    logic found;

    // Scan from ptr upward, wrapping; the first hit wins.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < n_clients; k++) begin
            logic [id_w-1:0] idx;
            idx = id_w'((int'(ptr) + k) % n_clients);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mul_arbiter.sv
// shared_mul_arbiter: one n-bit signed/unsigned multiplier shared by
// n_clients requesters through a round-robin arbiter and a 2-stage
// pipeline (operand register, product register).
//   clk, rst : clock, synchronous active-high reset
//   bus      : shared_mul_arbiter_if.slave request/response bundle
// Optional (macro SHARED_MUL_PERF_CNT_EN):
//   ops_cnt   : accepted requests, saturating
//   stall_cnt : cycles with res_valid && !res_ready, saturating
module shared_mul_arbiter
    import shared_mul_pkg::*;
#(
    parameter int n         = MUL_N,
    parameter int n_clients = MUL_CLIENTS
) (
    input  logic                    clk,
    input  logic                    rst,
    shared_mul_arbiter_if.slave     bus
`ifdef SHARED_MUL_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0]   ops_cnt,
    output logic [PERF_CNT_W-1:0]   stall_cnt
`endif
);

    localparam int id_w   = $clog2(n_clients);
    localparam int prod_w = 2 * n;

    logic [id_w-1:0]      ptr;
    logic [n_clients-1:0] grant;
    logic [id_w-1:0]      gid;
    logic                 adv1;
    logic                 adv2;
    logic                 xfer;
    logic [n_clients-1:0] ready;

    logic [n-1:0]         a_arr [n_clients];
    logic [n-1:0]         b_arr [n_clients];

    logic                 s1_valid;
    logic [n-1:0]         s1_a;
    logic [n-1:0]         s1_b;
    logic                 s1_signed;
    logic [id_w-1:0]      s1_id;

    logic                 s2_valid;
    logic [prod_w-1:0]    s2_res;
    logic [id_w-1:0]      s2_id;

    for (genvar i = 0; i < n_clients; i++) begin : g_unpack
        assign a_arr[i] = bus.req_a[i*n +: n];
        assign b_arr[i] = bus.req_b[i*n +: n];
    end

    // Grant ignores pipeline state; readiness only gates the handshake.
    rr_arbiter #(.n_clients(n_clients)) u_arb (
        .req      (bus.req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (gid)
    );

    assign adv2  = !s2_valid || bus.res_ready;
    assign adv1  = !s1_valid || adv2;
    assign ready = rst ? '0 : (grant & {n_clients{adv1}});
    assign xfer  = |(bus.req_valid & ready);

    assign bus.req_ready = ready;
    assign bus.res_valid = s2_valid;
    assign bus.res       = s2_res;
    assign bus.res_id    = s2_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_signed <= 1'b0;
            s1_id     <= '0;
            s2_valid  <= 1'b0;
            s2_res    <= '0;
            s2_id     <= '0;
        end else begin
            if (xfer) begin
                ptr <= (gid == id_w'(n_clients - 1)) ? '0 : gid + 1'b1;
            end
            // s1 may capture a non-granted client's operands when nothing
            // transfers; s1_valid keeps them from ever being used.
            if (adv1) begin
                s1_valid  <= xfer;
                s1_a      <= a_arr[gid];
                s1_b      <= b_arr[gid];
                s1_signed <= bus.req_signed[gid];
                s1_id     <= gid;
            end
            if (adv2) begin
                s2_valid <= s1_valid;
                s2_res   <= prod_w'(signed_or_unsigned_product(
                                MUL_MAX_N'(s1_a), MUL_MAX_N'(s1_b), s1_signed, n));
                s2_id    <= s1_id;
            end
        end
    end

`ifdef SHARED_MUL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer && ops_cnt != '1) begin
                ops_cnt <= ops_cnt + 1'b1;
            end
            if (s2_valid && !bus.res_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shared_mul_arbiter.sv
// Testbench for shared_mul_arbiter (n=8, n_clients=2). A negedge monitor
// pushes the expected product of every accepted request into a queue and
// pops/compares on every result handshake; scenario tasks add targeted
// checks for latency, arbitration order, backpressure and reset.
// Counter checks are compiled in when SHARED_MUL_PERF_CNT_EN is defined.
module tb_shared_mul_arbiter;
    import shared_mul_pkg::*;

    localparam int N  = 8;
    localparam int NC = 2;

    typedef struct {
        logic [0:0]  id;
        logic [15:0] p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shared_mul_arbiter_if #(.n(N), .n_clients(NC)) bus ();

`ifdef SHARED_MUL_PERF_CNT_EN
    logic [15:0] ops_cnt;
    logic [15:0] stall_cnt;
    shared_mul_arbiter #(.n(N), .n_clients(NC)) dut (
        .clk(clk), .rst(rst), .bus(bus), .ops_cnt(ops_cnt), .stall_cnt(stall_cnt));
`else
    shared_mul_arbiter #(.n(N), .n_clients(NC)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   n_res   = 0;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [63:0] f;
        f = signed_or_unsigned_product(32'(a), 32'(b), s, N);
        return f[15:0];
    endfunction

    function automatic logic [7:0] opa(input int k);
        return 8'(k * 37 + 5);
    endfunction

    function automatic logic [7:0] opb(input int k);
        return 8'(200 - k * 13);
    endfunction

    // Result leaving in a cycle is older than a request entering it, so
    // pop before push.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.res_valid && bus.res_ready) begin
                n_res++;
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_result: got id=%0d res=%h, expected no result", bus.res_id, bus.res);
                end else begin
                    e = sb.pop_front();
                    if (bus.res !== e.p || bus.res_id !== e.id) begin
                        errors++;
                        $display("FAIL scoreboard: got id=%0d res=%h, expected id=%0d res=%h",
                                 bus.res_id, bus.res, e.id, e.p);
                    end
                end
            end
            for (int i = 0; i < NC; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    sb.push_back('{id: 1'(i),
                                   p: model(bus.req_a[i*N +: N], bus.req_b[i*N +: N], bus.req_signed[i])});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
        bus.req_a[i*N +: N] = a;
        bus.req_b[i*N +: N] = b;
        bus.req_signed[i]   = s;
    endtask

    task automatic drain;
        for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
        tick();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic pulse_reset;
        tick();
        rst = 1'b1;
        bus.req_valid = '0;
        sb.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req_valid = '1;
        tick();
        @(negedge clk);
        vectors += 4;
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b, expected 0", bus.res_valid); end
        if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b, expected 00", bus.req_ready); end
        if (bus.res !== 16'h0) begin errors++; $display("FAIL reset_res: got %h, expected 0000", bus.res); end
        if (bus.res_id !== 1'b0) begin errors++; $display("FAIL reset_res_id: got %0d, expected 0", bus.res_id); end
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] exp_p);
        bit got = 0;
        tick();
        set_client(id, a, b, s);
        bus.req_valid = NC'(1) << id;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready[id]) begin got = 1; break; end
        end
        vectors++;
        if (!got) begin errors++; $display("FAIL op_accept_timeout: got no req_ready, expected accept within 20 cycles"); end
        tick();
        bus.req_valid = '0;
        @(negedge clk);
        vectors++;
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got res_valid=%b at T+1, expected 0", bus.res_valid); end
        @(negedge clk);
        vectors += 2;
        if (bus.res_valid !== 1'b1 || bus.res !== exp_p) begin
            errors++;
            $display("FAIL op_result: got valid=%b res=%h, expected valid=1 res=%h", bus.res_valid, bus.res, exp_p);
        end
        if (bus.res_id !== 1'(id)) begin errors++; $display("FAIL op_id: got %0d, expected %0d", bus.res_id, id); end
    endtask

    task automatic test_arith;
        bus.res_ready = 1'b1;
        do_op(0, 8'hF9, 8'hF9, 1'b1, 16'h0031);
        do_op(0, 8'hF9, 8'hF9, 1'b0, 16'hF231);
        do_op(0, 8'h80, 8'h80, 1'b1, 16'h4000);
        do_op(0, 8'hFF, 8'h01, 1'b1, 16'hFFFF);
        do_op(1, 8'h80, 8'h7F, 1'b0, 16'h3F80);
`ifdef SHARED_MUL_PERF_CNT_EN
        vectors++;
        if (ops_cnt !== 16'd5) begin errors++; $display("FAIL ops_cnt: got %0d, expected 5", ops_cnt); end
`endif
        drain();
    endtask

    task automatic test_round_robin;
        int sent[NC];
        pulse_reset();
        sent[0] = 0;
        sent[1] = 10;
        set_client(0, opa(sent[0]), opb(sent[0]), 1'b1);
        set_client(1, opa(sent[1]), opb(sent[1]), 1'b0);
        bus.req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            logic [1:0] exp_g;
            @(negedge clk);
            exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if (bus.req_ready !== exp_g) begin errors++; $display("FAIL rr_grant: cycle %0d got %b, expected %b", c, bus.req_ready, exp_g); end
            if (c >= 2) begin
                vectors++;
                if (bus.res_valid !== 1'b1 || bus.res_id !== 1'(c % 2)) begin
                    errors++;
                    $display("FAIL rr_res_id: cycle %0d got valid=%b id=%0d, expected valid=1 id=%0d", c, bus.res_valid, bus.res_id, c % 2);
                end
            end
            tick();
            sent[c % 2]++;
            set_client(c % 2, opa(sent[c % 2]), opb(sent[c % 2]), c % 2 == 0);
            if (c == 5) bus.req_valid = '0;
        end
        drain();
    endtask

    task automatic test_back_to_back;
        tick();
        set_client(1, opa(20), opb(20), 1'b1);
        bus.req_valid = 2'b10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL b2b_accept: op %0d got %b, expected 10", c, bus.req_ready); end
            tick();
            set_client(1, opa(21 + c), opb(21 + c), c[0]);
            if (c == 2) begin
                set_client(0, 8'h12, 8'h34, 1'b0);
                bus.req_valid = 2'b01;
            end
        end
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL b2b_client0: got %b, expected 01", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        drain();
    endtask

    task automatic test_backpressure;
        int          k = 0;
        int          res0;
        logic [15:0] hold_res;
        logic [0:0]  hold_id;
`ifdef SHARED_MUL_PERF_CNT_EN
        logic [15:0] stall0;
`endif
        res0 = n_res;
        for (int c = 0; c < 12; c++) begin
            tick();
            bus.res_ready = !(c >= 3 && c <= 6);
            bus.req_valid = (k < 7) ? 2'b01 : 2'b00;
            set_client(0, opa(30 + k), opb(30 + k), k[0]);
            @(negedge clk);
            if (c == 3) begin
`ifdef SHARED_MUL_PERF_CNT_EN
                stall0 = stall_cnt;
`endif
                hold_res = bus.res;
                hold_id  = bus.res_id;
                vectors += 3;
                if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, expected 1", bus.res_valid); end
                if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready: cycle %0d got %b, expected 00", c, bus.req_ready); end
                if (sb.size() != 2) begin errors++; $display("FAIL bp_buffered: got %0d ops in flight, expected 2", sb.size()); end
            end
            if (c >= 4 && c <= 6) begin
                vectors += 2;
                if (bus.res !== hold_res || bus.res_id !== hold_id || bus.res_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stable: cycle %0d got res=%h id=%0d, expected res=%h id=%0d", c, bus.res, bus.res_id, hold_res, hold_id);
                end
                if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready: cycle %0d got %b, expected 00", c, bus.req_ready); end
            end
`ifdef SHARED_MUL_PERF_CNT_EN
            if (c == 7) begin
                vectors++;
                if (stall_cnt - stall0 !== 16'd4) begin errors++; $display("FAIL stall_cnt: got +%0d, expected +4", stall_cnt - stall0); end
            end
`endif
            if (bus.req_valid[0] && bus.req_ready[0]) k++;
        end
        bus.req_valid = '0;
        drain();
        vectors++;
        if (n_res - res0 != 7 || k != 7) begin
            errors++;
            $display("FAIL bp_count: got %0d results for %0d accepts, expected 7 and 7", n_res - res0, k);
        end
    endtask

    task automatic test_reset_mid;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            set_client(0, opa(50 + c), opb(50 + c), 1'b1);
            bus.req_valid = 2'b01;
            @(negedge clk);
            vectors++;
            if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_accept: op %0d got %b, expected 01", c, bus.req_ready); end
        end
        tick();
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        bus.res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL mid_stale: cycle %0d got res_valid=%b, expected 0", c, bus.res_valid); end
            tick();
        end
        set_client(0, 8'h03, 8'h05, 1'b0);
        set_client(1, 8'h07, 8'h09, 1'b0);
        bus.req_valid = 2'b11;
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_ptr: got %b, expected 01", bus.req_ready); end
        tick();
        bus.req_valid = '0;
        drain();
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_signed = '0;
        bus.res_ready  = 1'b1;
        test_reset();
        test_arith();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
